wmul_seq: RTL

WMUL_SEQ -- requirements
Module: wmul_seq

---
 rtl/wmul_pkg.sv | 69 ++++++
 rtl/lane_mul.sv | 22 ++
 rtl/wmul_seq.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/wmul_pkg.sv
// ---------------------------------------------------------------------------
// wmul_pkg
// Shared definitions for the sequential widening multiplier (wmul_seq):
//   - element-width (ctrl_ww) encodings
//   - widening-multiply ALU opcodes
//   - controller state type and state constants
//   - lane multiplier operand width and small decode helpers
// Build option: define WMUL_W32_EN to make ctrl_ww=10 (32-bit elements) legal.
// Without it, the lane multipliers are 17x17 and ctrl_ww=10 is rejected.
// ---------------------------------------------------------------------------
package wmul_pkg;

   // Element width encodings
   localparam logic [1:0] WW_8   = 2'b00;
   localparam logic [1:0] WW_16  = 2'b01;
   localparam logic [1:0] WW_32  = 2'b10;
   localparam logic [1:0] WW_RSV = 2'b11;

   // Widening multiply opcodes: bit 0 selects odd elements, bit 1 selects signed
   localparam logic [4:0] OP_WMULEU = 5'h14;
   localparam logic [4:0] OP_WMULOU = 5'h15;
   localparam logic [4:0] OP_WMULES = 5'h16;
   localparam logic [4:0] OP_WMULOS = 5'h17;

   // Controller states
   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_RUN  = 2'd1;
   localparam state_t ST_DONE = 2'd2;

   // Lane operand width: widest element plus one bit so that unsigned
   // operands can be zero-extended into a signed multiplier.
`ifdef WMUL_W32_EN
   localparam int LANE_W = 33;
`else
   localparam int LANE_W = 17;
`endif

   function automatic logic is_wmul(input logic [4:0] op);
      return (op == OP_WMULEU) || (op == OP_WMULOU) ||
             (op == OP_WMULES) || (op == OP_WMULOS);
   endfunction

   function automatic logic op_odd(input logic [4:0] op);
      return (op == OP_WMULOU) || (op == OP_WMULOS);
   endfunction

   function automatic logic op_signed(input logic [4:0] op);
      return (op == OP_WMULES) || (op == OP_WMULOS);
   endfunction

   function automatic logic ww_legal(input logic [1:0] ww);
`ifdef WMUL_W32_EN
      return (ww == WW_8) || (ww == WW_16) || (ww == WW_32);
`else
      return (ww == WW_8) || (ww == WW_16);
`endif
   endfunction

   // Element width in bits for a (legal) ww code
   function automatic int elem_w(input logic [1:0] ww);
      case (ww)
         WW_16:   return 16;
         WW_32:   return 32;
         default: return 8;
      endcase
   endfunction

endpackage

// File: rtl/lane_mul.sv
// ---------------------------------------------------------------------------
// lane_mul
// One combinational signed multiplier lane. Operands arrive already sign- or
// zero-extended to LANE_W bits, so a single signed multiply covers both the
// signed and unsigned widening operations.
// Ports:
//   a, b : signed LANE_W-bit operands
//   p    : signed 2*LANE_W-bit product
// ---------------------------------------------------------------------------
module lane_mul
   import wmul_pkg::*;
#(
   parameter int W = LANE_W
) (
   input  logic signed [W-1:0]   a,
   input  logic signed [W-1:0]   b,
   output logic signed [2*W-1:0] p
);

   assign p = a * b;

endmodule

// File: rtl/wmul_seq.sv
// ---------------------------------------------------------------------------
// wmul_seq
// Sequential SIMD widening multiplier. Accepts one command in IDLE, then
// spends ceil(P/NUM_MUL) RUN cycles computing NUM_MUL element products per
// cycle, and holds the result in DONE until the consumer takes it.
// Vector layout: element 0 / lane 0 occupy the most-significant end of the
// vector (bit 0 of the layout is the MSB of the port).
// Ports:
//   clk, reset          : clock (rising edge), async active-high reset
//   in_valid, in_ready  : command handshake (in_ready only in IDLE)
//   reg_A, reg_B        : DATA_W-bit operand vectors
//   ctrl_ww             : element width 00 w8, 01 w16, 10 w32, 11 reserved
//   alu_op              : widening multiply opcode (see wmul_pkg)
//   out_valid, out_ready: result handshake
//   result              : DATA_W-bit product vector
//   out_err             : command was illegal (qualified by out_valid)
// Build option: WMUL_W32_EN enables 32-bit elements (32x32->64 products).
// ---------------------------------------------------------------------------
module wmul_seq
   import wmul_pkg::*;
#(
   parameter int DATA_W  = 128,
   parameter int NUM_MUL = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] reg_A,
   input  logic [DATA_W-1:0] reg_B,
   input  logic [1:0]        ctrl_ww,
   input  logic [4:0]        alu_op,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] result,
   output logic              out_err
);

   localparam int CNT_W = $clog2(DATA_W) + 1;

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  cnt_step;
   logic [DATA_W-1:0] a_q;
   logic [DATA_W-1:0] b_q;
   logic [DATA_W-1:0] result_q;
   logic [DATA_W-1:0] run_acc;
   logic [DATA_W-1:0] part [NUM_MUL];
   logic [1:0]        ww_q;
   logic              odd_q;
   logic              sgn_q;
   logic              err_q;
   logic              accept;
   logic              legal;
   int                nprod;

   // Number of products for the element width: DATA_W / (2*E)
   function automatic int num_prod(input logic [1:0] ww);
      return DATA_W / (2 * elem_w(ww));
   endfunction

   // Fetch element k (counted from the MSB end) and extend it to LANE_W bits
   function automatic logic signed [LANE_W-1:0] get_elem(
      input logic [DATA_W-1:0] v,
      input logic [1:0]        ww,
      input int                k,
      input logic              sgn
   );
      logic [DATA_W-1:0] sh;
      logic [LANE_W-1:0] e;
      sh = v << (k * elem_w(ww));
      case (ww)
         WW_16:   e = {{(LANE_W-16){sgn & sh[DATA_W-1]}}, sh[DATA_W-1 -: 16]};
`ifdef WMUL_W32_EN
         WW_32:   e = {{(LANE_W-32){sgn & sh[DATA_W-1]}}, sh[DATA_W-1 -: 32]};
`endif
         default: e = {{(LANE_W-8){sgn & sh[DATA_W-1]}}, sh[DATA_W-1 -: 8]};
      endcase
      return e;
   endfunction

   // Position the low 2E bits of a product into result lane idx
   function automatic logic [DATA_W-1:0] place(
      input logic signed [2*LANE_W-1:0] p,
      input logic [1:0]                 ww,
      input int                         idx
   );
      logic [DATA_W-1:0] v;
      v = '0;
      case (ww)
         WW_16:   v[DATA_W-1 -: 32] = p[31:0];
`ifdef WMUL_W32_EN
         WW_32:   v[DATA_W-1 -: 64] = p[63:0];
`endif
         default: v[DATA_W-1 -: 16] = p[15:0];
      endcase
      return v >> (idx * 2 * elem_w(ww));
   endfunction

   assign in_ready  = (state == ST_IDLE);
   assign out_valid = (state == ST_DONE);
   assign result    = result_q;
   assign out_err   = err_q;
   assign accept    = in_ready & in_valid;
   assign legal     = is_wmul(alu_op) & ww_legal(ctrl_ww);
   assign nprod     = num_prod(ww_q);
   assign cnt_step  = cnt + CNT_W'(NUM_MUL);

   // Lane m handles product cnt+m; lanes past the last product stay idle
   for (genvar m = 0; m < NUM_MUL; m++) begin : g_lane
      logic [CNT_W-1:0]           idx;
      logic                       hit;
      logic signed [LANE_W-1:0]   la;
      logic signed [LANE_W-1:0]   lb;
      logic signed [2*LANE_W-1:0] lp;

      assign idx = cnt + CNT_W'(m);
      assign hit = (state == ST_RUN) && (int'(idx) < nprod);
      assign la  = hit ? get_elem(a_q, ww_q, 2 * int'(idx) + int'(odd_q), sgn_q) : '0;
      assign lb  = hit ? get_elem(b_q, ww_q, 2 * int'(idx) + int'(odd_q), sgn_q) : '0;

      lane_mul #(.W(LANE_W)) u_mul (
         .a (la),
         .b (lb),
         .p (lp)
      );

      assign part[m] = hit ? place(lp, ww_q, int'(idx)) : '0;
   end

   always_comb begin
      run_acc = '0;
      for (int m = 0; m < NUM_MUL; m++) begin
         run_acc = run_acc | part[m];
      end
   end

   // Control and result: cleared on accept, each lane written exactly once
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         result_q <= '0;
         err_q    <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  cnt      <= '0;
                  result_q <= '0;
                  if (legal) begin
                     err_q <= 1'b0;
                     state <= ST_RUN;
                  end else begin
                     // Illegal commands skip RUN and report a zero result
                     err_q <= 1'b1;
                     state <= ST_DONE;
                  end
               end
            end
            ST_RUN: begin
               result_q <= result_q | run_acc;
               cnt      <= cnt_step;
               if (int'(cnt_step) >= nprod) begin
                  state <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  err_q <= 1'b0;
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Operand capture; only meaningful while a command is in flight
   always_ff @(posedge clk) begin
      if (accept) begin
         a_q   <= reg_A;
         b_q   <= reg_B;
         ww_q  <= ctrl_ww;
         odd_q <= op_odd(alu_op);
         sgn_q <= op_signed(alu_op);
      end
   end

endmodule
